// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Contents:
//   - register offsets, decoded from word-address bits [3:2]
//   - STATUS bit positions
//   - FSM state encoding
//   - BAUDDIV byte-lane merge helper
package mmio_uart_tx_pkg;

  // Register offsets (word index within the block's window).
  localparam logic [1:0] OffTxdata  = 2'd0;
  localparam logic [1:0] OffStatus  = 2'd1;
  localparam logic [1:0] OffBauddiv = 2'd2;

  // STATUS bit positions.
  localparam int unsigned StatBusy   = 0;
  localparam int unsigned StatFull   = 1;
  localparam int unsigned StatEmpty  = 2;
  localparam int unsigned StatOvf    = 3;
  localparam int unsigned StatCntLsb = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } tx_state_e;

  // Merges a byte-strobed write into the divisor.
  // A resulting divisor of zero is stored as one, so the bit timer always has a
  // non-zero period.
  function automatic logic [15:0] merge_div(input logic [15:0] cur,
                                            input logic [15:0] wdata,
                                            input logic [1:0]  stb);
    logic [15:0] merged;
    merged = cur;
    if (stb[0]) merged[7:0]  = wdata[7:0];
    if (stb[1]) merged[15:8] = wdata[15:8];
    return (merged == 16'd0) ? 16'd1 : merged;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Synchronous FIFO. It is reusable for the receive path.
//
// Ports:
//   clk_i, rst_i      clock; synchronous active-high reset
//   push_i, wdata_i   write request and data
//                     A push while full is accepted only when a pop happens in
//                     the same cycle.
//   pop_i             read request; ignored when empty
//   rdata_o           head-of-queue data (show-ahead)
//   full_o, empty_o   occupancy flags
//   count_o           number of stored entries
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned Aw   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [Aw:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [Aw-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [Aw:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (Aw+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // The pop is applied first, so a push into a full FIFO fits in the freed slot.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + Aw'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + Aw'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (Aw+1)'(1);
      2'b01:   count_d = count_q - (Aw+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter (LSB first) with a transmit FIFO.
//
// Ports:
//   CLK, RST           clock; synchronous active-high reset
//   SEL                address-window decode hit; qualifies WE and RE
//   ADDR               word address [31:2]; only bits [3:2] are decoded
//   WDATA, WSTB, WE    lane-placed store data, byte strobes, store strobe
//   RE                 load strobe (reads have no side effects)
//   RDATA              combinational read data; 0 when SEL is low
//   TXD                registered serial output; idles high
//   TX_IDLE            registered; FIFO empty and FSM idle
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        SEL,
  input  logic [29:0] ADDR,
  input  logic [31:0] WDATA,
  input  logic [3:0]  WSTB,
  input  logic        WE,
  input  logic        RE,
  output logic [31:0] RDATA,
  output logic        TXD,
  output logic        TX_IDLE
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  tx_state_e   state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [15:0] timer_q, timer_d;
  logic [15:0] frame_div_q, frame_div_d;
  logic [15:0] div_q, div_d;
  logic        ovf_q, ovf_d;
  logic        txd_q, txd_d;
  logic        tx_idle_q, tx_idle_d;

  logic [1:0]      off;
  logic            wr_hit, push_req, pop, load, timer_done;
  logic            fifo_full, fifo_empty;
  logic [7:0]      fifo_rdata;
  logic [CntW-1:0] fifo_count;
  logic            unused;

  assign unused = ^{ADDR[29:2], WDATA[31:16], WSTB[3:2], RE};

  assign off      = ADDR[1:0];
  assign wr_hit   = SEL && WE;
  assign push_req = wr_hit && (off == OffTxdata) && WSTB[0];

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (CLK),
    .rst_i  (RST),
    .push_i (push_req),
    .wdata_i(WDATA[7:0]),
    .pop_i  (pop),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  // Register file.
  always_comb begin
    ovf_d = ovf_q;
    div_d = div_q;
    if (push_req && fifo_full && !pop) ovf_d = 1'b1;
    if (wr_hit && (off == OffStatus) && WSTB[0] && WDATA[StatOvf]) ovf_d = 1'b0;
    if (wr_hit && (off == OffBauddiv)) div_d = merge_div(div_q, WDATA[15:0], WSTB[1:0]);
  end

  always_comb begin
    RDATA = '0;
    if (SEL) begin
      case (off)
        OffStatus:  RDATA = {16'd0, 8'(fifo_count), 4'd0, ovf_q, fifo_empty, fifo_full,
                             (state_q != StIdle)};
        OffBauddiv: RDATA = {16'd0, div_q};
        default:    RDATA = '0;
      endcase
    end
  end

  // Transmit FSM and bit timer.
  // The divisor is latched per frame, so BAUDDIV writes only affect later frames.
  assign timer_done = (timer_q == 16'd0);

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    timer_d     = timer_q;
    frame_div_d = frame_div_q;
    load        = 1'b0;
    pop         = 1'b0;

    unique case (state_q)
      StIdle: begin
        load = !fifo_empty;
      end
      StStart: begin
        if (timer_done) begin
          state_d   = StData;
          bit_idx_d = 3'd0;
          timer_d   = frame_div_q - 16'd1;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      StData: begin
        if (timer_done) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
          timer_d   = frame_div_q - 16'd1;
          if (bit_idx_q == 3'd7) state_d = StStop;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      StStop: begin
        if (timer_done) begin
          // Chain straight into the next frame when data is waiting.
          load    = !fifo_empty;
          state_d = StIdle;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      pop         = 1'b1;
      shift_d     = fifo_rdata;
      frame_div_d = div_q;
      timer_d     = div_q - 16'd1;
      state_d     = StStart;
    end
  end

  // The pin follows the current state one cycle later, which keeps it glitch-free.
  always_comb begin
    unique case (state_q)
      StStart: txd_d = 1'b0;
      StData:  txd_d = shift_q[0];
      default: txd_d = 1'b1;
    endcase
    tx_idle_d = fifo_empty && (state_q == StIdle);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      timer_q     <= '0;
      frame_div_q <= DEFAULT_DIV;
      div_q       <= DEFAULT_DIV;
      ovf_q       <= 1'b0;
      txd_q       <= 1'b1;
      tx_idle_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      timer_q     <= timer_d;
      frame_div_q <= frame_div_d;
      div_q       <= div_d;
      ovf_q       <= ovf_d;
      txd_q       <= txd_d;
      tx_idle_q   <= tx_idle_d;
    end
  end

  assign TXD     = txd_q;
  assign TX_IDLE = tx_idle_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register map, frame shape, back-to-back
// frames, FIFO overflow, divisor latching and mid-frame reset.
module tb_mmio_uart_tx;

  localparam logic [1:0] OTx = 2'd0, OSt = 2'd1, ODiv = 2'd2, ORsv = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic [29:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstb = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [31:0] rdata;
  logic        txd, tx_idle;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mmio_uart_tx #(
    .FIFO_DEPTH (16),
    .DEFAULT_DIV(16'd434)
  ) dut (
    .CLK    (clk),
    .RST    (rst),
    .SEL    (sel),
    .ADDR   (addr),
    .WDATA  (wdata),
    .WSTB   (wstb),
    .WE     (we),
    .RE     (re),
    .RDATA  (rdata),
    .TXD    (txd),
    .TX_IDLE(tx_idle)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; occupies one clock and returns at the next negedge.
  task automatic bus_write(input logic [1:0] off, input logic [31:0] data, input logic [3:0] stb);
    sel = 1'b1; we = 1'b1; addr = {28'd0, off}; wdata = data; wstb = stb;
    @(negedge clk);
    sel = 1'b0; we = 1'b0; wstb = '0;
  endtask

  // Combinational read; consumes no clock edge.
  task automatic bus_read(input logic [1:0] off, output logic [31:0] data);
    sel = 1'b1; re = 1'b1; addr = {28'd0, off};
    #1;
    data = rdata;
    sel = 1'b0; re = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [1:0] off, input logic [31:0] exp);
    logic [31:0] v;
    bus_read(off, v);
    check_eq(tag, v, exp);
  endtask

  task automatic wait_fall(input string tag, input int budget);
    int waited = 0;
    while (txd !== 1'b0 && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    if (txd !== 1'b0) check_eq({tag, "_fall_timeout"}, 32'(txd), 32'd0);
  endtask

  // Starts on the first low cycle of the start bit; returns on the cycle after the stop bit.
  task automatic recv_frame(input int div, input logic [7:0] exp_byte, input string tag);
    int bad = 0;
    logic [7:0] got = '0;
    for (int c = 0; c < 10 * div; c++) begin
      int b;
      logic e;
      b = c / div;
      if (b == 0) e = 1'b0;
      else if (b == 9) e = 1'b1;
      else e = exp_byte[b-1];
      if (txd !== e) bad++;
      if (b >= 1 && b <= 8 && (c % div) == div / 2) got[b-1] = txd;
      @(negedge clk);
    end
    check_eq({tag, "_shape_errs"}, 32'(bad), 32'd0);
    check_eq({tag, "_byte"}, {24'd0, got}, {24'd0, exp_byte});
  endtask

  initial begin
    logic [7:0] t3_bytes [3];
    int lows;
    t3_bytes[0] = 8'hA1; t3_bytes[1] = 8'h3C; t3_bytes[2] = 8'hFF;

    // Reset and register map.
    @(negedge clk);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_txd", 32'(txd), 32'd1);
    check_eq("rst_idle", 32'(tx_idle), 32'd1);
    addr = {28'd0, OSt}; sel = 1'b0; #1;
    check_eq("rdata_nosel", rdata, 32'd0);
    check_reg("rst_status", OSt, 32'h0000_0004);
    check_reg("rst_div", ODiv, 32'd434);
    check_reg("txdata_reads0", OTx, 32'd0);
    bus_write(ODiv, 32'd0, 4'b0011);
    check_reg("div_zero_is_one", ODiv, 32'd1);
    bus_write(ODiv, 32'h0000_1200, 4'b0010);
    check_reg("div_lane1", ODiv, 32'h0000_1201);
    bus_write(ORsv, 32'hFFFF_FFFF, 4'b1111);
    check_reg("rsv_reads0", ORsv, 32'd0);

    // Single frame, divisor 4, with push/pop/fall latency.
    bus_write(ODiv, 32'd4, 4'b0011);
    bus_write(OTx, 32'h55, 4'b0001);
    check_reg("t2_status_k", OSt, 32'h0000_0100);
    check_eq("t2_txd_k", 32'(txd), 32'd1);
    @(negedge clk);
    check_reg("t2_status_k1", OSt, 32'h0000_0005);
    check_eq("t2_txd_k1", 32'(txd), 32'd1);
    @(negedge clk);
    check_eq("t2_txd_k2", 32'(txd), 32'd0);
    check_eq("t2_busy_idle", 32'(tx_idle), 32'd0);
    recv_frame(4, 8'h55, "t2");
    check_eq("t2_idle_at40", 32'(tx_idle), 32'd1);
    check_reg("t2_status_end", OSt, 32'h0000_0004);

    // Three back-to-back frames, divisor 2.
    bus_write(ODiv, 32'd2, 4'b0011);
    for (int i = 0; i < 3; i++) bus_write(OTx, {24'd0, t3_bytes[i]}, 4'b0001);
    wait_fall("t3", 10);
    for (int i = 0; i < 3; i++) recv_frame(2, t3_bytes[i], $sformatf("t3_f%0d", i));
    check_eq("t3_txd_end", 32'(txd), 32'd1);

    // Overflow: 18 pushes into a 16-deep FIFO while the first frame is slow.
    bus_write(ODiv, 32'd1000, 4'b0011);
    for (int i = 0; i < 18; i++) bus_write(OTx, 32'(i), 4'b0001);
    check_reg("t4_status_full", OSt, 32'h0000_100B);
    bus_write(OSt, 32'h8, 4'b0001);
    check_reg("t4_ovf_clear", OSt, 32'h0000_1003);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reg("t4_status_rst", OSt, 32'h0000_0004);

    // Divisor change mid-frame only affects the following frame.
    bus_write(ODiv, 32'd8, 4'b0011);
    bus_write(OTx, 32'h96, 4'b0001);
    bus_write(OTx, 32'h3B, 4'b0001);
    wait_fall("t5", 10);
    fork
      recv_frame(8, 8'h96, "t5_old_div");
      begin
        repeat (12) @(negedge clk);
        bus_write(ODiv, 32'd3, 4'b0011);
      end
    join
    recv_frame(3, 8'h3B, "t5_new_div");

    // Reset during data bit 4 with two bytes queued.
    bus_write(ODiv, 32'd4, 4'b0011);
    bus_write(OTx, 32'h0F, 4'b0001);
    bus_write(OTx, 32'hAA, 4'b0001);
    bus_write(OTx, 32'h33, 4'b0001);
    wait_fall("t6", 10);
    repeat (20) @(negedge clk);
    check_eq("t6_bit4_low", 32'(txd), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t6_txd_after_rst", 32'(txd), 32'd1);
    check_eq("t6_idle_after_rst", 32'(tx_idle), 32'd1);
    rst = 1'b0;
    check_reg("t6_status", OSt, 32'h0000_0004);
    lows = 0;
    for (int i = 0; i < 80; i++) begin
      if (txd !== 1'b1) lows++;
      @(negedge clk);
    end
    check_eq("t6_no_more_frames", 32'(lows), 32'd0);
    check_reg("t6_div_default", ODiv, 32'd434);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
